// File: rtl/ex_mem_buf.sv
// Elastic EX/MEM stage: DEPTH-entry in-order buffer, valid/ready on both sides, 1-cycle latency.
// in_ready depends only on occupancy, never on out_ready; outputs read as a NOP bubble when empty.
module ex_mem_buf #(
    parameter int DATA_W  = 32,
    parameter int PC_W    = 32,
    parameter int RADDR_W = 5,
    parameter int DEPTH   = 2,
    parameter int CNT_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [PC_W-1:0]              in_pc,
    input  logic                         in_wreg,
    input  logic [RADDR_W-1:0]           in_rw,
    input  logic [DATA_W-1:0]            in_wdata,
    input  logic                         in_whilo,
    input  logic [DATA_W-1:0]            in_hi,
    input  logic [DATA_W-1:0]            in_lo,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PC_W-1:0]              out_pc,
    output logic                         out_wreg,
    output logic [RADDR_W-1:0]           out_rw,
    output logic [DATA_W-1:0]            out_wdata,
    output logic                         out_whilo,
    output logic [DATA_W-1:0]            out_hi,
    output logic [DATA_W-1:0]            out_lo,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [CNT_W-1:0]             stall_cycles
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic               wreg;
        logic [RADDR_W-1:0] rw;
        logic [DATA_W-1:0]  wdata;
        logic               whilo;
        logic [DATA_W-1:0]  hi;
        logic [DATA_W-1:0]  lo;
    } entry_t;

    entry_t             mem [DEPTH];
    entry_t             in_entry;
    entry_t             head;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic               push;
    logic               pop;

    assign in_entry  = '{pc: in_pc, wreg: in_wreg, rw: in_rw, wdata: in_wdata,
                         whilo: in_whilo, hi: in_hi, lo: in_lo};
    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately not reset; the output gating below hides stale entries.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) mem[wr_ptr] <= in_entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (out_valid && !out_ready && !flush && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

    assign head      = mem[rd_ptr];
    assign out_pc    = out_valid ? head.pc    : '0;
    assign out_wreg  = out_valid ? head.wreg  : 1'b0;
    assign out_rw    = out_valid ? head.rw    : '0;
    assign out_wdata = out_valid ? head.wdata : '0;
    assign out_whilo = out_valid ? head.whilo : 1'b0;
    assign out_hi    = out_valid ? head.hi    : '0;
    assign out_lo    = out_valid ? head.lo    : '0;
endmodule
